i2c_reg_target: RTL and testbench
=================================

# i2c_reg_target

I2C target (responder) that lets an external host load the synth's eight 16-bit voice registers over the same two-wire bus that `synth_top` exposes on `sda_io`/`scl_io`. It decodes START/STOP, matches a 7-bit device address, and ACKs bytes. Write transactions become single-cycle register write strobes. Read transactions return register contents MSB-first. It sits on the board-side end of the bus and feeds a register file that drives the PWM voice generators.

## Interface
- `TARGET_ADDR`, 7'h2A, 7-bit I2C device address matched after START.
- `NUM_REGS_LOG2`, 3, register pointer width; the pointer wraps modulo 2^NUM_REGS_LOG2.
- `clk_io`  in  1  system clock, 10 MHz; the only clock.
- `reset_io`  in  1  synchronous, active-high reset.
- `scl_in`  in  1  raw SCL from the pad; asynchronous to `clk_io`.
- `sda_in`  in  1  raw SDA from the pad; asynchronous.
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_addr`  out  NUM_REGS_LOG2  current register pointer; valid for both writes and reads.
- `reg_wr_data`  out  16  write word; valid while `reg_wr_en`=1.
- `reg_rd_data`  in  16  register file output for `reg_addr` (combinational read).
- `busy`  out  1  1 from an address-matched START until STOP or the next START.

## Operation
- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer followed by a previous-value flop. Edge and START/STOP detection use the synchronized values only.
- START: synced SDA 1→0 while synced SCL=1. STOP: synced SDA 0→1 while SCL=1. Both are recognised in any state, including mid-byte.
  - START (including repeated START): bit counter cleared, go to ADDR.
  - STOP: go to IDLE, `sda_oe`=0, `busy`=0.
- Data bits are sampled on the synced SCL rising edge, MSB first. SDA is only changed in the cycle after a synced SCL falling edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_HI, WR_LO, WR_ACK, RD_HI, RD_LO, RD_MACK, IGNORE.
- ADDR: shift 8 bits.
  - Bits[7:1]==TARGET_ADDR: ADDR_ACK, `busy`=1. R/W=0 leads to PTR. R/W=1 leads to RD_HI.
  - Mismatch: IGNORE. No ACK; `sda_oe` stays 0 until STOP or START.
- ADDR_ACK, PTR_ACK and WR_ACK: `sda_oe`=1 from the falling edge after bit 8 until the next falling edge.
- PTR: 8 bits; `reg_addr` ← low NUM_REGS_LOG2 bits, upper bits ignored. ACK, then WR_HI.
- WR_HI: byte into `reg_wr_data[15:8]`, ACK, then WR_LO.
- WR_LO: byte into `reg_wr_data[7:0]`, ACK.
  - `reg_wr_en` pulses exactly one cycle, on the SCL rising edge of the ACK clock.
  - `reg_addr` increments (wrapping) the cycle after the pulse.
  - Return to WR_HI.
- A high byte with no following low byte (STOP or START in WR_LO) produces no write.
- Read:
  - On entering RD_HI, snapshot `reg_rd_data` into a 16-bit shift register. This prevents tearing if the register file changes mid-word.
  - Drive `sda_oe` = ~bit for the 16 bits: 8 bits RD_HI, 8 bits RD_LO.
  - In each master-ACK slot (RD_MACK after each byte), release SDA and sample the host ACK/NACK.
  - After the low byte, host ACK (SDA=0) increments `reg_addr` (wrapping) and returns to RD_HI with a new snapshot.
  - Host NACK goes to IGNORE with SDA released; wait for STOP or START.
- Reset values: `sda_oe`=0, `reg_wr_en`=0, `reg_addr`=0, `reg_wr_data`=0, `busy`=0, state IDLE, bit counter 0.
- Reset mid-transaction: all outputs take reset values on the next clock edge. The bus is released immediately. No partial write is ever issued.

## Timing
- SCL high and low phases must each be ≥4 `clk_io` cycles (100 kHz at 10 MHz gives 50).
- Detection latency: a pad edge is seen 2–3 cycles later; START/STOP are seen 3 cycles after the pad SDA edge.
- SDA drive update: 1 cycle after the synced SCL falling-edge detect. This gives ≥3 cycles of hold after the pad falling edge.
- `reg_wr_en`: exactly 1 cycle per complete word. `reg_wr_data` and `reg_addr` are stable during that cycle.
- Snapshot of `reg_rd_data` is taken the cycle RD_HI is entered. The register file must present data combinationally from `reg_addr`.
- A SCL rising edge and a START/STOP detected in the same cycle: START/STOP wins.

## Test plan
- Write word:
  - Stimulus: START, 0x54, 0x03, 0x12, 0x34, STOP.
  - Response: ACK on all 4 bytes; one `reg_wr_en` pulse with `reg_addr`=3 and `reg_wr_data`=0x1234; `reg_addr`=4 afterwards; `busy` falls on STOP.
- Address mismatch:
  - Stimulus: START, 0x56, 0xFF, STOP.
  - Response: `sda_oe` never asserts; no `reg_wr_en`; `busy` stays 0.
- Pointer wrap:
  - Stimulus: write ptr 0x07 then words 0xAAAA, 0x5555.
  - Response: writes to addr 7 then addr 0; `reg_addr`=1 at STOP.
- Read with repeated START:
  - Stimulus: START, 0x54, 0x05, repeated START, 0x55; bench register file returns 0xBEEF at 5 and 0x0102 at 6; host ACKs the first word and NACKs after 0x01.
  - Response: bytes 0xBE, 0xEF, 0x01; SDA released after the NACK.
- Truncated write:
  - Stimulus: START, 0x54, 0x02, 0x99, STOP.
  - Response: no `reg_wr_en`; `reg_addr`=2.
- Reset mid-ACK:
  - Stimulus: assert `reset_io` while `sda_oe`=1 during the ADDR_ACK slot.
  - Response: `sda_oe`=0 and `busy`=0 at the next edge; a following full write transaction succeeds normally.

Source files
------------

// File: rtl/i2c_reg_target.sv
// I2C target that exposes a small 16-bit register file: pointer byte, then
// big-endian words written or read with auto-incrementing pointer.
module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR   = 7'h2A,
  parameter int         NUM_REGS_LOG2 = 3
) (
  input  logic                     clk_io,
  input  logic                     reset_io,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic                     reg_wr_en,
  output logic [NUM_REGS_LOG2-1:0] reg_addr,
  output logic [15:0]              reg_wr_data,
  input  logic [15:0]              reg_rd_data,
  output logic                     busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_HI, WR_LO, WR_ACK,
    RD_HI, RD_LO, RD_MACK, IGNORE
  } state_t;

  localparam logic [NUM_REGS_LOG2-1:0] ADDR_ONE = 1;

  // Pad synchronizers; not reset so they keep tracking the bus through reset.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_p, sda_p;
  logic       scl_s, sda_s;

  always_ff @(posedge clk_io) begin
    scl_sync <= {scl_sync[0], scl_in};
    sda_sync <= {sda_sync[0], sda_in};
    scl_p    <= scl_sync[1];
    sda_p    <= sda_sync[1];
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  state_t                     state, state_n;
  logic [3:0]                 bit_cnt, bit_cnt_n;
  logic [7:0]                 shreg, shreg_n;
  logic [15:0]                rd_sh, rd_sh_n;
  logic                       rw, rw_n;
  logic                       second, second_n;
  logic                       nack, nack_n;
  logic                       sda_oe_n, wr_en_n, busy_n;
  logic [NUM_REGS_LOG2-1:0]   addr_n;
  logic [15:0]                wr_data_n;

  always_ff @(posedge clk_io) begin
    if (reset_io) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      rd_sh       <= '0;
      rw          <= 1'b0;
      second      <= 1'b0;
      nack        <= 1'b0;
      sda_oe      <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      rd_sh       <= rd_sh_n;
      rw          <= rw_n;
      second      <= second_n;
      nack        <= nack_n;
      sda_oe      <= sda_oe_n;
      reg_wr_en   <= wr_en_n;
      reg_addr    <= addr_n;
      reg_wr_data <= wr_data_n;
      busy        <= busy_n;
    end
  end

  // Write contract: reg_wr_en is a one-cycle strobe with no back-pressure;
  // reg_addr and reg_wr_data hold steady during it, and reg_addr advances
  // in the cycle after.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rd_sh_n   = rd_sh;
    rw_n      = rw;
    second_n  = second;
    nack_n    = nack;
    sda_oe_n  = sda_oe;
    wr_en_n   = 1'b0;
    addr_n    = reg_wr_en ? reg_addr + ADDR_ONE : reg_addr;
    wr_data_n = reg_wr_data;
    busy_n    = busy;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WR_HI, WR_LO: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            sda_oe_n  = 1'b1;
            case (state)
              ADDR: begin
                if (shreg[7:1] == TARGET_ADDR) begin
                  state_n = ADDR_ACK;
                  busy_n  = 1'b1;
                  rw_n    = shreg[0];
                end else begin
                  state_n  = IGNORE;
                  sda_oe_n = 1'b0;
                end
              end
              PTR: begin
                state_n = PTR_ACK;
                addr_n  = shreg[NUM_REGS_LOG2-1:0];
              end
              WR_HI: begin
                state_n          = WR_ACK;
                wr_data_n[15:8]  = shreg;
                second_n         = 1'b0;
              end
              default: begin
                state_n          = WR_ACK;
                wr_data_n[7:0]   = shreg;
                second_n         = 1'b1;
              end
            endcase
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              // First data bit goes out on the same edge the snapshot is taken.
              state_n  = RD_HI;
              rd_sh_n  = reg_rd_data;
              sda_oe_n = ~reg_rd_data[15];
            end else begin
              state_n  = PTR;
              sda_oe_n = 1'b0;
            end
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            state_n  = WR_HI;
            sda_oe_n = 1'b0;
          end
        end

        WR_ACK: begin
          if (scl_rise && second) begin
            wr_en_n = 1'b1;
          end else if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = second ? WR_HI : WR_LO;
          end
        end

        RD_HI, RD_LO: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            rd_sh_n = {rd_sh[14:0], 1'b0};
            if (bit_cnt == 4'd8) begin
              bit_cnt_n = '0;
              sda_oe_n  = 1'b0;
              state_n   = RD_MACK;
              second_n  = (state == RD_LO);
            end else begin
              sda_oe_n = ~rd_sh[14];
            end
          end
        end

        RD_MACK: begin
          if (scl_rise) begin
            nack_n = sda_s;
            // Advance early so the next snapshot sees the new register.
            if (!sda_s && second) addr_n = reg_addr + ADDR_ONE;
          end else if (scl_fall) begin
            if (nack) begin
              state_n = IGNORE;
            end else if (second) begin
              state_n  = RD_HI;
              rd_sh_n  = reg_rd_data;
              sda_oe_n = ~reg_rd_data[15];
            end else begin
              state_n  = RD_LO;
              sda_oe_n = ~rd_sh[15];
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged bus host, register file, and a
// word-level model of pointer/auto-increment behaviour.
module tb_i2c_reg_target;

  localparam int W = 19;

  logic        clk_io = 1'b0;
  logic        reset_io = 1'b1;
  logic        scl_in = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic        reg_wr_en;
  logic [2:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic [15:0] reg_rd_data;
  logic        busy;

  always #50 clk_io = ~clk_io;

  assign sda_in = m_sda & ~sda_oe;

  i2c_reg_target #(.TARGET_ADDR(7'h2A), .NUM_REGS_LOG2(3)) dut (
    .clk_io      (clk_io),
    .reset_io    (reset_io),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .reg_wr_en   (reg_wr_en),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  // Board-side register file
  logic [15:0] bench_rf [8] = '{default: 16'h0000};
  logic        poke_en = 1'b0;
  logic [2:0]  poke_addr = 3'd0;
  logic [15:0] poke_data = 16'h0000;

  assign reg_rd_data = bench_rf[reg_addr];

  always @(posedge clk_io) begin
    if (poke_en) bench_rf[poke_addr] <= poke_data;
    else if (reg_wr_en) bench_rf[reg_addr] <= reg_wr_data;
  end

  // Monitor
  logic [W-1:0] obs_q[$];
  int           oe_cnt = 0;
  int           busy_cnt = 0;
  int           dbl_cnt = 0;
  logic         prev_wr = 1'b0;

  always @(negedge clk_io) begin
    if (reg_wr_en) begin
      obs_q.push_back({reg_addr, reg_wr_data});
      if (prev_wr) dbl_cnt++;
    end
    prev_wr = reg_wr_en;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  // Scoreboard and model state
  logic [W-1:0] exp_q[$];
  int           obs_idx = 0;
  logic [15:0]  model_rf [8] = '{default: 16'h0000};
  logic [2:0]   model_ptr = 3'd0;
  logic [15:0]  wbuf [4];
  int           half = 8;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_io);
  endtask

  task automatic i2c_start();
    clks(2); m_sda = 1'b1;
    clks(half); scl_in = 1'b1;
    clks(half); m_sda = 1'b0;
    clks(half); scl_in = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(2); m_sda = 1'b0;
    clks(half); scl_in = 1'b1;
    clks(half); m_sda = 1'b1;
    clks(half);
  endtask

  task automatic write_bit(input logic b);
    clks(2); m_sda = b;
    clks(half - 2); scl_in = 1'b1;
    clks(half); scl_in = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    clks(2); m_sda = 1'b1;
    clks(half - 2); scl_in = 1'b1;
    clks(half / 2);
    @(negedge clk_io); b = sda_in;
    clks(half - half / 2); scl_in = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic send_ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      read_bit(r);
      b[i] = r;
    end
    write_bit(~send_ack);
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(posedge clk_io);
    poke_en = 1'b0;
  endtask

  task automatic sb_check();
    clks(2);
    check("wr_count", obs_q.size() - obs_idx, exp_q.size());
    while (exp_q.size() > 0 && obs_idx < obs_q.size()) begin
      check("wr_word", obs_q[obs_idx], exp_q.pop_front());
      obs_idx++;
    end
    exp_q.delete();
    obs_idx = obs_q.size();
    check("wr_single", dbl_cnt, 0);
  endtask

  task automatic do_write(input logic [7:0] ptr, input int nwords, input logic trunc,
                          input logic [7:0] tbyte);
    logic        ack;
    logic [15:0] w;
    i2c_start();
    write_byte(8'h54, ack); check("w_adr_ack", ack, 1);
    write_byte(ptr, ack);   check("w_ptr_ack", ack, 1);
    model_ptr = ptr[2:0];
    for (int i = 0; i < nwords; i++) begin
      w = wbuf[i];
      write_byte(w[15:8], ack); check("w_hi_ack", ack, 1);
      write_byte(w[7:0], ack);  check("w_lo_ack", ack, 1);
      exp_q.push_back({model_ptr, w});
      model_rf[model_ptr] = w;
      model_ptr = model_ptr + 3'd1;
    end
    if (trunc) begin
      write_byte(tbyte, ack); check("w_trunc_ack", ack, 1);
    end
    @(negedge clk_io); check("w_busy_mid", busy, 1);
    i2c_stop();
    clks(2);
    @(negedge clk_io);
    check("w_busy_end", busy, 0);
    check("w_addr_end", reg_addr, model_ptr);
    sb_check();
  endtask

  task automatic do_read(input logic [7:0] ptr, input int nbytes, input logic poke_mid);
    logic        ack, last;
    logic [7:0]  b;
    logic [15:0] cur;
    i2c_start();
    write_byte(8'h54, ack); check("r_adr_ack", ack, 1);
    write_byte(ptr, ack);   check("r_ptr_ack", ack, 1);
    model_ptr = ptr[2:0];
    i2c_start();
    write_byte(8'h55, ack); check("r_adr2_ack", ack, 1);
    cur = 16'h0000;
    for (int k = 0; k < nbytes; k++) begin
      if (k % 2 == 0) cur = model_rf[model_ptr];
      last = (k == nbytes - 1);
      read_byte(b, ~last);
      if (k % 2 == 0) check("rd_hi", b, cur[15:8]);
      else check("rd_lo", b, cur[7:0]);
      if (poke_mid && k == 0) begin
        model_rf[model_ptr] = ~cur;
        poke(model_ptr, ~cur);
      end
      if (k % 2 == 1 && !last) model_ptr = model_ptr + 3'd1;
    end
    clks(4);
    @(negedge clk_io); check("rd_release", sda_oe, 0);
    i2c_stop();
    clks(2);
    @(negedge clk_io);
    check("r_busy_end", busy, 0);
    check("r_addr_end", reg_addr, model_ptr);
    sb_check();
  endtask

  task automatic do_mismatch(input logic [7:0] abyte);
    logic ack;
    int   oe0, busy0;
    oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    write_byte(abyte, ack); check("m_adr_nack", ack, 0);
    write_byte(8'hFF, ack); check("m_data_nack", ack, 0);
    i2c_stop();
    clks(2);
    @(negedge clk_io);
    check("m_oe_cycles", oe_cnt - oe0, 0);
    check("m_busy_cycles", busy_cnt - busy0, 0);
    check("m_addr", reg_addr, model_ptr);
    sb_check();
  endtask

  initial begin
    #(90_000 * 100);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b54;
    logic [6:0] a7;
    int         t;

    clks(5);
    @(negedge clk_io);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wr_data", reg_wr_data, 0);
    check("rst_busy", busy, 0);
    reset_io = 1'b0;
    clks(5);

    wbuf[0] = 16'h1234;
    do_write(8'h03, 1, 1'b0, 8'h00);

    do_mismatch(8'h56);

    wbuf[0] = 16'hAAAA; wbuf[1] = 16'h5555;
    do_write(8'h07, 2, 1'b0, 8'h00);

    wbuf[0] = 16'hBEEF; wbuf[1] = 16'h0102;
    do_write(8'h05, 2, 1'b0, 8'h00);
    do_read(8'h05, 3, 1'b1);

    do_write(8'h02, 0, 1'b1, 8'h99);

    // Reset while the address ACK is being driven
    b54 = 8'h54;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(b54[i]);
    t = 0;
    while (t < 40) begin
      @(negedge clk_io);
      if (sda_oe) break;
      t++;
    end
    check("rst_ack_seen", sda_oe, 1);
    reset_io = 1'b1;
    @(posedge clk_io); #1;
    check("rst_mid_oe", sda_oe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", reg_addr, 0);
    clks(3);
    reset_io = 1'b0;
    model_ptr = 3'd0;
    clks(3);
    wbuf[0] = 16'hC3A5;
    do_write(8'h04, 1, 1'b0, 8'h00);
    do_read(8'h04, 2, 1'b0);

    for (int it = 0; it < 12; it++) begin
      half = $urandom_range(5, 10);
      case ($urandom_range(0, 3))
        0: begin
          for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom_range(0, 65535));
          do_write(8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'b0, 8'h00);
        end
        1: do_read(8'($urandom_range(0, 255)), $urandom_range(1, 5), 1'b0);
        2: begin
          for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom_range(0, 65535));
          do_write(8'($urandom_range(0, 255)), $urandom_range(0, 1), 1'b1,
                   8'($urandom_range(0, 255)));
        end
        default: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h2A) a7 = 7'h2B;
          do_mismatch({a7, 1'($urandom_range(0, 1))});
        end
      endcase
    end

    do_read(8'h00, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
